// File: rtl/mux_sweep_pkg.sv
// Shared definitions for the exhaustive mux sweep checker: FSM states,
// the sweep length and the golden model of the circuit under test.
package mux_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NUM_VECTORS = 8;

  // Golden behaviour of the select circuit z = (a & ~c) | (c & b).
  function automatic logic mux_expect(input logic a, input logic b, input logic c);
    return c ? b : a;
  endfunction

endpackage

// File: rtl/mux_sweep_checker.sv
// Exhaustive stimulus/check stage for the 3-input select circuit.
// Drives {a,b,c} = k for k = 0..7, holds each vector for SETTLE_CYCLES
// cycles, samples z just before the closing edge and scores it against
// the golden value. Results are held in DONE until the next start.
module mux_sweep_checker
  import mux_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1  // legal range 1..15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       z,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [3:0] pass_count,
  output logic [3:0] fail_count,
  output logic [7:0] fail_mask
);

  // Settle counter runs 0 .. SETTLE_CYCLES-1; the sample happens on the
  // edge that closes the last settle cycle of a vector.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LAST_VEC    = 3'(NUM_VECTORS - 1);

  state_e     state_q,  state_d;
  logic [3:0] settle_q, settle_d;
  logic [2:0] vec_q,    vec_d;     // vector index, doubles as the stimulus
  logic [3:0] pass_q,   pass_d;
  logic [3:0] fail_q,   fail_d;
  logic [7:0] mask_q,   mask_d;

  logic exp_z;
  logic z_match;

  assign exp_z   = mux_expect(vec_q[2], vec_q[1], vec_q[0]);
  // Case equality: an X or Z on z never matches, so it scores as a fail.
  assign z_match = (z === exp_z);

  // Next-state logic: FSM, settle counter, vector index and scoreboard.
  always_comb begin
    // NOTE: every variable gets a default here so no path infers a latch.
    state_d  = state_q;
    settle_d = settle_q;
    vec_d    = vec_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    mask_d   = mask_q;

    case (state_q)
      IDLE, DONE: begin
        // A new sweep clears results and drives vector 0 on the start edge.
        if (start) begin
          state_d  = RUN;
          settle_d = '0;
          vec_d    = '0;
          pass_d   = '0;
          fail_d   = '0;
          mask_d   = '0;
        end
      end

      RUN: begin
        // start is deliberately ignored here: a sweep is never restarted.
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          if (z_match) begin
            pass_d = pass_q + 4'd1;
          end else begin
            fail_d        = fail_q + 4'd1;
            mask_d[vec_q] = 1'b1;
          end
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
            vec_d   = '0;   // stimulus returns to 0 once results are held
          end else begin
            vec_d = vec_q + 3'd1;
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      default: begin
        state_d  = IDLE;
        settle_d = '0;
        vec_d    = '0;
      end
    endcase
  end

  // State register with synchronous reset; reset wins over start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: all state here is plain flops (no memory array), so all of it
      // is reset and an aborted sweep leaves no partial results behind.
      state_q  <= IDLE;
      settle_q <= '0;
      vec_q    <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      mask_q   <= mask_d;
    end
  end

  assign a          = vec_q[2];
  assign b          = vec_q[1];
  assign c          = vec_q[0];
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign fail_mask  = mask_q;

endmodule
